// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
// Groups the two pipeline handshakes around the decode stage:
//   upstream   : valid_i / ready_o, inst_i, pc_i        (fetch -> decode)
//   downstream : valid_o / ready_i, registered bundle    (decode -> execute)
// Modports:
//   slave  : the decode stage itself
//   master : the surrounding pipeline (fetch source and execute sink)
// ---------------------------------------------------------------------------
interface decode_stage_if;
   // fetch -> decode
   logic        valid_i;
   logic        ready_o;
   logic [31:0] inst_i;
   logic [31:0] pc_i;

   // decode -> execute
   logic        valid_o;
   logic        ready_i;
   logic [31:0] pc_o;
   logic [31:0] imm_o;
   logic [31:0] rs1_val_o;
   logic [31:0] rs2_val_o;
   logic [4:0]  rd_o;
   logic [6:0]  opcode_o;
   logic [2:0]  funct3_o;
   logic        funct7b5_o;
   logic        rd_wen_o;

   modport slave (
      input  valid_i, inst_i, pc_i, ready_i,
      output ready_o, valid_o, pc_o, imm_o, rs1_val_o, rs2_val_o,
             rd_o, opcode_o, funct3_o, funct7b5_o, rd_wen_o
   );

   modport master (
      output valid_i, inst_i, pc_i, ready_i,
      input  ready_o, valid_o, pc_o, imm_o, rs1_val_o, rs2_val_o,
             rd_o, opcode_o, funct3_o, funct7b5_o, rd_wen_o
   );
endinterface

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// RV32I instruction decode: field extraction, immediate generation, operand
// bypass from EX/MEM/WB, load-use stall, single registered ID/EX slot.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   pipe (slave)              upstream/downstream handshakes and ID/EX bundle
//   flush_i                   kill held bundle and incoming instruction
//   rs1/rs2_addr_o            register-file read addresses (combinational)
//   rs1/rs2_data_i            register-file read data
//   ex_*/mem_*/wb_*           producer write-back info used for bypassing
// ---------------------------------------------------------------------------
module decode_stage (
   input  logic                 clk_i,
   input  logic                 rst_i,
   decode_stage_if.slave        pipe,
   input  logic                 flush_i,
   output logic [4:0]           rs1_addr_o,
   output logic [4:0]           rs2_addr_o,
   input  logic [31:0]          rs1_data_i,
   input  logic [31:0]          rs2_data_i,
   input  logic                 ex_wen_i,
   input  logic                 ex_is_load_i,
   input  logic [4:0]           ex_waddr_i,
   input  logic [31:0]          ex_wdata_i,
   input  logic                 mem_wen_i,
   input  logic [4:0]           mem_waddr_i,
   input  logic [31:0]          mem_wdata_i,
   input  logic                 wb_wen_i,
   input  logic [4:0]           wb_waddr_i,
   input  logic [31:0]          wb_wdata_i
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   logic [31:0]       inst;
   logic [6:0]        opcode;
   logic [REG_AW-1:0] rd, rs1, rs2;
   logic              use_rs1, use_rs2, wen_class;
   logic [XLEN-1:0]   imm;
   logic [XLEN-1:0]   rs1_val, rs2_val;
   logic              ld_in_ex, hazard, slot_open, accept;

   // Field extraction
   assign inst       = pipe.inst_i;
   assign opcode     = inst[6:0];
   assign rd         = inst[11:7];
   assign rs1        = inst[19:15];
   assign rs2        = inst[24:20];
   assign rs1_addr_o = rs1;
   assign rs2_addr_o = rs2;

   assign use_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));

   // Immediate format, rs2 usage and write-enable class per opcode
   always_comb begin
      imm       = '0;
      use_rs2   = 1'b0;
      wen_class = 1'b0;
      case (opcode)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
            imm       = {{20{inst[31]}}, inst[31:20]};
            wen_class = 1'b1;
         end
         OPC_STORE: begin
            imm     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            use_rs2 = 1'b1;
         end
         OPC_BRANCH: begin
            imm     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            use_rs2 = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            imm       = {inst[31:12], 12'b0};
            wen_class = 1'b1;
         end
         OPC_JAL: begin
            imm       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            wen_class = 1'b1;
         end
         OPC_OP: begin
            use_rs2   = 1'b1;
            wen_class = 1'b1;
         end
         default: ;
      endcase
   end

   // Bypass select, youngest producer first. A matching load in EX blocks
   // older matches; if the source is used, the hazard stalls anyway.
   function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] a,
                                           input logic [XLEN-1:0]   rf_data);
      if (a == '0)
         return '0;
      if (ex_wen_i && (ex_waddr_i == a))
         return ex_is_load_i ? rf_data : ex_wdata_i;
      if (mem_wen_i && (mem_waddr_i == a))
         return mem_wdata_i;
      if (wb_wen_i && (wb_waddr_i == a))
         return wb_wdata_i;
      return rf_data;
   endfunction

   always_comb begin
      rs1_val = fwd(rs1, rs1_data_i);
      rs2_val = fwd(rs2, rs2_data_i);
   end

   // Load-use hazard against the sources this opcode actually reads
   assign ld_in_ex = ex_wen_i && ex_is_load_i && (ex_waddr_i != '0);
   assign hazard   = ld_in_ex && ((use_rs1 && (ex_waddr_i == rs1)) ||
                                  (use_rs2 && (ex_waddr_i == rs2)));

   assign slot_open    = !pipe.valid_o || pipe.ready_i;
   assign pipe.ready_o = flush_i || (!hazard && slot_open);
   assign accept       = pipe.valid_i && pipe.ready_o;

   // ID/EX slot; a held bundle is never re-forwarded since only older
   // producers exist downstream of it
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe.valid_o    <= 1'b0;
         pipe.pc_o       <= '0;
         pipe.imm_o      <= '0;
         pipe.rs1_val_o  <= '0;
         pipe.rs2_val_o  <= '0;
         pipe.rd_o       <= '0;
         pipe.opcode_o   <= '0;
         pipe.funct3_o   <= '0;
         pipe.funct7b5_o <= 1'b0;
         pipe.rd_wen_o   <= 1'b0;
      end else if (flush_i) begin
         pipe.valid_o <= 1'b0;
      end else if (slot_open) begin
         pipe.valid_o <= pipe.valid_i && !hazard;
         if (accept) begin
            pipe.pc_o       <= pipe.pc_i;
            pipe.imm_o      <= imm;
            pipe.rs1_val_o  <= rs1_val;
            pipe.rs2_val_o  <= rs2_val;
            pipe.rd_o       <= rd;
            pipe.opcode_o   <= opcode;
            pipe.funct3_o   <= inst[14:12];
            pipe.funct7b5_o <= inst[30];
            pipe.rd_wen_o   <= wen_class && (rd != '0);
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Self-checking bench for decode_stage. Expected bundles are queued when an
// instruction is driven and compared when the DUT hands one downstream.
// ---------------------------------------------------------------------------
module tb_decode_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        flush_i;
   logic [4:0]  rs1_addr_o, rs2_addr_o;
   logic [31:0] rs1_data_i, rs2_data_i;
   logic        ex_wen_i, ex_is_load_i;
   logic [4:0]  ex_waddr_i;
   logic [31:0] ex_wdata_i;
   logic        mem_wen_i;
   logic [4:0]  mem_waddr_i;
   logic [31:0] mem_wdata_i;
   logic        wb_wen_i;
   logic [4:0]  wb_waddr_i;
   logic [31:0] wb_wdata_i;

   decode_stage_if bus ();

   always #5 clk_i = ~clk_i;

   decode_stage dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .pipe        (bus),
      .flush_i     (flush_i),
      .rs1_addr_o  (rs1_addr_o),
      .rs2_addr_o  (rs2_addr_o),
      .rs1_data_i  (rs1_data_i),
      .rs2_data_i  (rs2_data_i),
      .ex_wen_i    (ex_wen_i),
      .ex_is_load_i(ex_is_load_i),
      .ex_waddr_i  (ex_waddr_i),
      .ex_wdata_i  (ex_wdata_i),
      .mem_wen_i   (mem_wen_i),
      .mem_waddr_i (mem_waddr_i),
      .mem_wdata_i (mem_wdata_i),
      .wb_wen_i    (wb_wen_i),
      .wb_waddr_i  (wb_waddr_i),
      .wb_wdata_i  (wb_wdata_i)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7b5;
      logic        wen;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [4:0] rd, input logic [6:0] opc,
                               input logic [2:0] f3, input logic f7b5, input logic wen);
      exp_t e;
      e.pc = pc; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
      e.opc = opc; e.f3 = f3; e.f7b5 = f7b5; e.wen = wen;
      return e;
   endfunction

   // Scoreboard: every downstream transfer must match the oldest expectation
   always @(negedge clk_i) begin
      if (rst_i === 1'b0 && bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
         exp_t got, e;
         got = {bus.pc_o, bus.imm_o, bus.rs1_val_o, bus.rs2_val_o, bus.rd_o,
                bus.opcode_o, bus.funct3_o, bus.funct7b5_o, bus.rd_wen_o};
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output pc=%h (scoreboard empty)", bus.pc_o);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               fails++;
               $display("FAIL bundle pc=%h got=%h exp=%h", e.pc, got, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      bus.valid_i  = 1'b0;
      bus.inst_i   = 32'h0;
      bus.pc_i     = 32'h0;
      bus.ready_i  = 1'b1;
      flush_i      = 1'b0;
      rs1_data_i   = 32'h0;
      rs2_data_i   = 32'h0;
      ex_wen_i     = 1'b0;
      ex_is_load_i = 1'b0;
      ex_waddr_i   = 5'd0;
      ex_wdata_i   = 32'h0;
      mem_wen_i    = 1'b0;
      mem_waddr_i  = 5'd0;
      mem_wdata_i  = 32'h0;
      wb_wen_i     = 1'b0;
      wb_waddr_i   = 5'd0;
      wb_wdata_i   = 32'h0;
   endtask

   task automatic set_load_in_ex(input logic [4:0] rd);
      ex_wen_i     = 1'b1;
      ex_is_load_i = 1'b1;
      ex_waddr_i   = rd;
      ex_wdata_i   = 32'hBAD0_BAD0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_i       = 1'b1;
      bus.valid_i = 1'b1;
      bus.inst_i  = 32'h0050_0093;
      bus.pc_i    = 32'hFFFF_0000;
      tick();
      tick();
      tests++;
      if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
      tests++;
      if (bus.pc_o !== 32'h0 || bus.imm_o !== 32'h0) begin
         fails++; $display("FAIL reset_fields pc=%h imm=%h exp=0", bus.pc_o, bus.imm_o);
      end
      tests++;
      if (bus.rd_wen_o !== 1'b0 || bus.rd_o !== 5'd0) begin
         fails++; $display("FAIL reset_rd got wen=%b rd=%0d exp=0", bus.rd_wen_o, bus.rd_o);
      end
      idle_inputs();
      rst_i = 1'b0;
      #1;
      tests++;
      if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
   endtask

   task automatic test_addi();
      bus.valid_i = 1'b1;
      bus.inst_i  = 32'h0050_0093;
      bus.pc_i    = 32'h0000_0100;
      sb.push_back(mk(32'h100, 32'd5, 32'h0, 32'h0, 5'd1, 7'h13, 3'd0, 1'b0, 1'b1));
      #1;
      tests++;
      if (rs1_addr_o !== 5'd0 || rs2_addr_o !== 5'd5) begin
         fails++; $display("FAIL addi_raddr got=%0d/%0d exp=0/5", rs1_addr_o, rs2_addr_o);
      end
      tick();
      bus.valid_i = 1'b0;
      tests++;
      if (bus.valid_o !== 1'b1 || bus.rd_o !== 5'd1) begin
         fails++; $display("FAIL addi_latency got valid=%b rd=%0d exp 1/1", bus.valid_o, bus.rd_o);
      end
      tick();
   endtask

   task automatic test_bypass();
      // EX beats MEM on rs1, WB serves rs2
      bus.valid_i = 1'b1;
      bus.inst_i  = 32'h0020_81B3;
      bus.pc_i    = 32'h0000_0200;
      rs1_data_i  = 32'h77; rs2_data_i = 32'h99;
      ex_wen_i  = 1'b1; ex_waddr_i  = 5'd1; ex_wdata_i  = 32'h11;
      mem_wen_i = 1'b1; mem_waddr_i = 5'd1; mem_wdata_i = 32'h22;
      wb_wen_i  = 1'b1; wb_waddr_i  = 5'd2; wb_wdata_i  = 32'h33;
      sb.push_back(mk(32'h200, 32'h0, 32'h11, 32'h33, 5'd3, 7'h33, 3'd0, 1'b0, 1'b1));
      #1;
      tests++;
      if (rs1_addr_o !== 5'd1 || rs2_addr_o !== 5'd2) begin
         fails++; $display("FAIL add_raddr got=%0d/%0d exp=1/2", rs1_addr_o, rs2_addr_o);
      end
      tick();
      // MEM beats WB on rs2, rs1 falls through to the register file
      bus.pc_i  = 32'h0000_0204;
      ex_wen_i  = 1'b0;
      mem_waddr_i = 5'd2; mem_wdata_i = 32'h44;
      wb_waddr_i  = 5'd2; wb_wdata_i  = 32'h55;
      sb.push_back(mk(32'h204, 32'h0, 32'h77, 32'h44, 5'd3, 7'h33, 3'd0, 1'b0, 1'b1));
      tick();
      // x0 sources are never forwarded
      bus.inst_i = 32'h0000_01B3;
      bus.pc_i   = 32'h0000_0208;
      ex_wen_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hDEAD;
      mem_waddr_i = 5'd0; wb_waddr_i = 5'd0;
      sb.push_back(mk(32'h208, 32'h0, 32'h0, 32'h0, 5'd3, 7'h33, 3'd0, 1'b0, 1'b1));
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_load_use();
      set_load_in_ex(5'd5);
      bus.valid_i = 1'b1;
      bus.inst_i  = 32'h0002_8333;
      bus.pc_i    = 32'h0000_0300;
      for (int i = 0; i < 2; i++) begin
         #1;
         tests++;
         if (bus.ready_o !== 1'b0) begin fails++; $display("FAIL loaduse_ready cyc=%0d got=%b exp=0", i, bus.ready_o); end
         tick();
         tests++;
         if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL loaduse_bubble cyc=%0d got=%b exp=0", i, bus.valid_o); end
      end
      // load has moved to MEM
      ex_wen_i = 1'b0; ex_is_load_i = 1'b0;
      mem_wen_i = 1'b1; mem_waddr_i = 5'd5; mem_wdata_i = 32'hAB;
      sb.push_back(mk(32'h300, 32'h0, 32'hAB, 32'h0, 5'd6, 7'h33, 3'd0, 1'b0, 1'b1));
      #1;
      tests++;
      if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL loaduse_release got=%b exp=1", bus.ready_o); end
      tick();
      // lui does not read rs1, so no stall
      mem_wen_i = 1'b0;
      set_load_in_ex(5'd5);
      bus.inst_i = 32'h0002_82B7;
      bus.pc_i   = 32'h0000_0310;
      sb.push_back(mk(32'h310, 32'h0002_8000, 32'h0, 32'h0, 5'd5, 7'h37, 3'd0, 1'b0, 1'b1));
      #1;
      tests++;
      if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL loaduse_lui got=%b exp=1", bus.ready_o); end
      tick();
      // load to x0 is never a hazard
      set_load_in_ex(5'd0);
      bus.inst_i = 32'h0000_0333;
      bus.pc_i   = 32'h0000_0320;
      sb.push_back(mk(32'h320, 32'h0, 32'h0, 32'h0, 5'd6, 7'h33, 3'd0, 1'b0, 1'b1));
      #1;
      tests++;
      if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL loaduse_x0 got=%b exp=1", bus.ready_o); end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_backpressure();
      bus.valid_i = 1'b1;
      bus.inst_i  = 32'h0050_0093;
      bus.pc_i    = 32'h0000_0400;
      sb.push_back(mk(32'h400, 32'd5, 32'h0, 32'h0, 5'd1, 7'h13, 3'd0, 1'b0, 1'b1));
      tick();
      bus.ready_i = 1'b0;
      bus.inst_i  = 32'h0070_0113;
      bus.pc_i    = 32'h0000_0404;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (bus.ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, bus.ready_o); end
         tests++;
         if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h400 || bus.imm_o !== 32'd5 || bus.rd_o !== 5'd1) begin
            fails++;
            $display("FAIL bp_hold cyc=%0d got v=%b pc=%h imm=%h rd=%0d exp 1/400/5/1",
                     i, bus.valid_o, bus.pc_o, bus.imm_o, bus.rd_o);
         end
         tick();
      end
      bus.ready_i = 1'b1;
      sb.push_back(mk(32'h404, 32'd7, 32'h0, 32'h0, 5'd2, 7'h13, 3'd0, 1'b0, 1'b1));
      #1;
      tests++;
      if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL bp_release got=%b exp=1", bus.ready_o); end
      tick();
      bus.valid_i = 1'b0;
      tests++;
      if (bus.pc_o !== 32'h404) begin fails++; $display("FAIL bp_next got pc=%h exp=404", bus.pc_o); end
      tick();
   endtask

   task automatic test_flush();
      idle_inputs();
      tick();
      // fill the slot while downstream is stalled; this one is later killed
      bus.ready_i = 1'b0;
      bus.valid_i = 1'b1;
      bus.inst_i  = 32'h0010_0493;
      bus.pc_i    = 32'h0000_0500;
      tick();
      tests++;
      if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h500) begin
         fails++; $display("FAIL flush_fill got v=%b pc=%h exp 1/500", bus.valid_o, bus.pc_o);
      end
      set_load_in_ex(5'd5);
      bus.inst_i = 32'h0002_8333;
      bus.pc_i   = 32'h0000_0504;
      flush_i    = 1'b1;
      #1;
      tests++;
      if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL flush_ready got=%b exp=1", bus.ready_o); end
      tick();
      tests++;
      if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL flush_clear got=%b exp=0", bus.valid_o); end
      idle_inputs();
      tick();
      tick();
      tests++;
      if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL flush_ghost got=%b exp=0", bus.valid_o); end
   endtask

   task automatic test_reset_mid_stall();
      bus.ready_i = 1'b0;
      bus.valid_i = 1'b1;
      bus.inst_i  = 32'h0010_0493;
      bus.pc_i    = 32'h0000_0600;
      tick();
      set_load_in_ex(5'd5);
      bus.inst_i = 32'h0002_8333;
      bus.pc_i   = 32'h0000_0604;
      #1;
      tests++;
      if (bus.ready_o !== 1'b0) begin fails++; $display("FAIL rststall_ready got=%b exp=0", bus.ready_o); end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      tests++;
      if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL rststall_valid got=%b exp=0", bus.valid_o); end
      ex_wen_i = 1'b0; ex_is_load_i = 1'b0;
      bus.valid_i = 1'b0;
      #1;
      tests++;
      if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL rststall_ready_after got=%b exp=1", bus.ready_o); end
      idle_inputs();
      tick();
   endtask

   task automatic test_back_to_back_imm();
      logic [31:0] insts [6];
      exp_t        exps  [6];
      insts[0] = 32'hFE20_AE23; exps[0] = mk(32'h700, 32'hFFFF_FFFC, 0, 0, 5'd28, 7'h23, 3'd2, 1'b1, 1'b0);
      insts[1] = 32'hFE00_0CE3; exps[1] = mk(32'h704, 32'hFFFF_FFF8, 0, 0, 5'd25, 7'h63, 3'd0, 1'b1, 1'b0);
      insts[2] = 32'h1234_52B7; exps[2] = mk(32'h708, 32'h1234_5000, 0, 0, 5'd5,  7'h37, 3'd5, 1'b0, 1'b1);
      insts[3] = 32'h0010_00EF; exps[3] = mk(32'h70C, 32'h0000_0800, 0, 0, 5'd1,  7'h6F, 3'd0, 1'b0, 1'b1);
      insts[4] = 32'h0000_00FF; exps[4] = mk(32'h710, 32'h0,         0, 0, 5'd1,  7'h7F, 3'd0, 1'b0, 1'b0);
      insts[5] = 32'h0010_0013; exps[5] = mk(32'h714, 32'h1,         0, 0, 5'd0,  7'h13, 3'd0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         bus.valid_i = 1'b1;
         bus.inst_i  = insts[i];
         bus.pc_i    = exps[i].pc;
         sb.push_back(exps[i]);
         #1;
         tests++;
         if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready idx=%0d got=%b exp=1", i, bus.ready_o); end
         tick();
      end
      bus.valid_i = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_addi();
      test_bypass();
      test_load_use();
      test_backpressure();
      test_flush();
      test_reset_mid_stall();
      test_back_to_back_imm();
      tests++;
      if (sb.size() != 0) begin
         fails++; $display("FAIL scoreboard_drain got=%0d left exp=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
